byte_serial_add_ctrl: RTL and testbench

- Controller that sequences a shared 8-bit adder slice (the carry-select 8-bit adder) to add or subtract wide operands one byte per cycle.
- Accepts an operation over a valid/ready request channel and drives the slice's operand and carry-in ports, LSB byte first.
- Chains the carry through a register and returns the assembled result over a valid/ready response channel.
- Sits between the ALU issue logic and a single 8-bit adder instance, so wide arithmetic costs no extra adder area.

---
 rtl/byte_serial_add_ctrl.sv | 159 +++++++++++++++
 tb/tb_byte_serial_add_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// byte_serial_add_ctrl
//
// Sequences one shared 8-bit adder slice to add or subtract W-bit operands,
// one byte per cycle, LSB first. The carry is chained through a register
// between bytes, so wide arithmetic needs no adder beyond the external slice.
//
// Parameters:
//   NBYTES     operand bytes (2..16), W = 8*NBYTES
//
// Compile-time option:
//   BYTE_SERIAL_ADD_BACK2BACK_EN  when defined, a new request can be accepted
//                                 in DONE on the same edge that retires the
//                                 previous result (skips the IDLE cycle).
//
// Ports:
//   clock, reset_n           clock (rising edge), async active-low reset
//   in_valid / in_ready      request handshake
//   op_a, op_b, sub          operands; sub=1 computes A - B
//   out_valid / out_ready    response handshake
//   result, cout, overflow   W-bit result, MSB carry (sub: 1 = no borrow),
//                            signed overflow
//   add_a, add_b, add_cin    drive to the adder slice (0 outside RUN)
//   add_sum, add_cout        combinational return from the adder slice
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for a request, in_ready=1
// RUN   | one byte per cycle through the adder slice, carry chained
// DONE  | result/cout/overflow held, out_valid=1 until out_ready
// -----------------------------------------------------------------------------
module byte_serial_add_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*NBYTES-1:0] op_a,
  input  logic [8*NBYTES-1:0] op_b,
  input  logic                sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES-1:0] result,
  output logic                cout,
  output logic                overflow,
  output logic [7:0]          add_a,
  output logic [7:0]          add_b,
  output logic                add_cin,
  input  logic [7:0]          add_sum,
  input  logic                add_cout
);

  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                    state;
  logic [NBYTES-1:0][7:0]    a_q;
  logic [NBYTES-1:0][7:0]    b_q;      // effective B (inverted for subtract)
  logic [NBYTES-1:0][7:0]    res_q;
  logic [IW-1:0]             idx;
  logic                      carry_q;
  logic                      cout_q;
  logic                      ovf_q;
  logic                      valid_q;
  logic                      last_byte;
  logic                      accept;

`ifdef BYTE_SERIAL_ADD_BACK2BACK_EN
  // A retiring result frees the controller on the same edge.
  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
`else
  assign in_ready = (state == IDLE);
`endif

  assign accept    = in_valid && in_ready;
  assign last_byte = (idx == IW'(NBYTES - 1));

  assign result    = res_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;
  assign out_valid = valid_q;

  always_comb begin
    add_a   = 8'd0;
    add_b   = 8'd0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = a_q[idx];
      add_b   = b_q[idx];
      add_cin = carry_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      idx     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      // Operand load is shared by IDLE and (optionally) DONE; accept is
      // never true in RUN, so the RUN branch below owns carry_q/idx there.
      // Subtraction is A + ~B + 1, with the +1 entering as the first carry.
      if (accept) begin
        a_q     <= op_a;
        b_q     <= sub ? ~op_b : op_b;
        carry_q <= sub;
        idx     <= '0;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            state <= RUN;
          end
        end

        RUN: begin
          res_q[idx] <= add_sum;
          carry_q    <= add_cout;
          if (last_byte) begin
            cout_q  <= add_cout;
            // Signed overflow: operand signs agree but the result sign differs.
            ovf_q   <= (a_q[NBYTES-1][7] == b_q[NBYTES-1][7]) &&
                       (add_sum[7] != a_q[NBYTES-1][7]);
            valid_q <= 1'b1;
            state   <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        DONE: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            state   <= accept ? RUN : IDLE;
          end
        end

        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_byte_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_byte_serial_add_ctrl
//
// Directed and random operations against byte_serial_add_ctrl (NBYTES=4),
// with an arithmetic reference model and a behavioural 8-bit adder slice.
// -----------------------------------------------------------------------------
module tb_byte_serial_add_ctrl;

  localparam int NB = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        cout;
  logic        overflow;
  logic [7:0]  add_a;
  logic [7:0]  add_b;
  logic        add_cin;
  logic [7:0]  add_sum;
  logic        add_cout;

  int checks = 0;
  int errors = 0;

  byte_serial_add_ctrl #(.NBYTES(NB)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .overflow  (overflow),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout)
  );

  // External 8-bit adder slice.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain W-bit arithmetic plus true signed result range check.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] r, output logic co, output logic ov);
    longint sa;
    longint sb;
    longint t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (s) begin
      r  = a - b;
      co = (a >= b);
      t  = sa - sb;
    end else begin
      r  = a + b;
      co = (({32'd0, a} + {32'd0, b}) > 64'h0000_0000_FFFF_FFFF);
      t  = sa + sb;
    end
    ov = (t > 64'sd2147483647) || (t < -64'sd2147483648);
  endfunction

  // Carry into byte i = carry out of the low i bytes of A + Beff + sub.
  function automatic logic exp_cin(input logic [31:0] a, input logic [31:0] b,
                                   input logic s, input int i);
    logic [63:0] beff;
    logic [63:0] mask;
    logic [63:0] sum;
    if (i == 0) return s;
    beff = {32'd0, (s ? ~b : b)};
    mask = (64'd1 << (8 * i)) - 64'd1;
    sum  = ({32'd0, a} & mask) + (beff & mask) + {63'd0, s};
    return sum[8 * i];
  endfunction

  task automatic accept_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clock);
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    op_a = a;
    op_b = b;
    sub = s;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    op_a = $urandom;
    op_b = $urandom;
    sub = 1'($urandom_range(0, 1));
  endtask

  task automatic run_phase(input logic [31:0] a, input logic [31:0] b, input logic s, input int nrun);
    logic [31:0] beff;
    beff = s ? ~b : b;
    for (int i = 0; i < nrun; i++) begin
      @(negedge clock);
      chk("run_out_valid", {31'd0, out_valid}, 32'd0);
      chk("run_add_a", {24'd0, add_a}, {24'd0, a[8*i +: 8]});
      chk("run_add_b", {24'd0, add_b}, {24'd0, beff[8*i +: 8]});
      chk("run_add_cin", {31'd0, add_cin}, {31'd0, exp_cin(a, b, s, i)});
      @(posedge clock);
    end
  endtask

  task automatic check_done(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] r;
    logic co;
    logic ov;
    model(a, b, s, r, co, ov);
    @(negedge clock);
    chk("done_out_valid", {31'd0, out_valid}, 32'd1);
    chk("done_result", result, r);
    chk("done_cout", {31'd0, cout}, {31'd0, co});
    chk("done_overflow", {31'd0, overflow}, {31'd0, ov});
    chk("done_in_ready", {31'd0, in_ready}, 32'd0);
    chk("done_add_a", {24'd0, add_a}, 32'd0);
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    @(negedge clock);
    chk("retired_out_valid", {31'd0, out_valid}, 32'd0);
    chk("retired_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic full_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    accept_op(a, b, s);
    run_phase(a, b, s, NB);
    check_done(a, b, s);
    retire();
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    logic [31:0] er;
    logic        eco;
    logic        eov;
    int          cyc;
    int          t1;
    int          t2;
    int          exp_gap;

    // Reset state
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_add_a", {24'd0, add_a}, 32'd0);
    chk("rst_add_b", {24'd0, add_b}, 32'd0);
    chk("rst_add_cin", {31'd0, add_cin}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Directed arithmetic cases
    full_op(32'h0000_00FF, 32'h0000_0001, 1'b0);
    full_op(32'h0000_0005, 32'h0000_0007, 1'b1);
    full_op(32'h0000_0007, 32'h0000_0005, 1'b1);
    full_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    full_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    full_op(32'h8000_0000, 32'h0000_0001, 1'b1);
    full_op(32'h8000_0000, 32'h8000_0000, 1'b0);
    full_op(32'h0000_0000, 32'h0000_0000, 1'b1);

    // Random operations
    for (int k = 0; k < 12; k++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      full_op(ra, rb, rs);
    end

    // Backpressure in DONE with competing requests
    ra = 32'h89AB_CDEF;
    rb = 32'h7654_3210;
    accept_op(ra, rb, 1'b0);
    run_phase(ra, rb, 1'b0, NB);
    check_done(ra, rb, 1'b0);
    model(ra, rb, 1'b0, er, eco, eov);
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      in_valid = 1'b1;
      op_a = $urandom;
      op_b = $urandom;
      sub = 1'(k);
      #1;
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_result", result, er);
      chk("bp_cout", {31'd0, cout}, {31'd0, eco});
      chk("bp_overflow", {31'd0, overflow}, {31'd0, eov});
    end
    in_valid = 1'b0;
    retire();
    @(negedge clock);
    chk("bp_no_second_op", {31'd0, out_valid}, 32'd0);
    chk("bp_idle_in_ready", {31'd0, in_ready}, 32'd1);

    // Asynchronous reset part-way through RUN
    accept_op(32'h1234_5678, 32'h1111_1111, 1'b0);
    run_phase(32'h1234_5678, 32'h1111_1111, 1'b0, 2);
    @(negedge clock);
    chk("mid_run_low_bytes", {16'd0, result[15:0]}, 32'h0000_6789);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_result", result, 32'd0);
    chk("mid_rst_add_a", {24'd0, add_a}, 32'd0);
    @(negedge clock);
    chk("mid_rst_held_out_valid", {31'd0, out_valid}, 32'd0);
    reset_n = 1'b1;
    #1;
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    full_op(32'h0000_0001, 32'h0000_0001, 1'b0);

    // Back-to-back throughput with in_valid and out_ready held high
`ifdef BYTE_SERIAL_ADD_BACK2BACK_EN
    exp_gap = NB + 1;
`else
    exp_gap = NB + 2;
`endif
    @(negedge clock);
    op_a = 32'h0102_0304;
    op_b = 32'h1010_1010;
    sub = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    cyc = 0;
    t1 = -1;
    t2 = -1;
    for (int k = 0; k < 40 && t2 < 0; k++) begin
      @(negedge clock);
      cyc++;
      if (out_valid === 1'b1) begin
        if (t1 < 0) begin
          t1 = cyc;
          chk("b2b_first_result", result, 32'h1112_1314);
          op_a = 32'h0000_0009;
          op_b = 32'h0000_000A;
          sub = 1'b1;
        end else begin
          t2 = cyc;
          chk("b2b_second_result", result, 32'hFFFF_FFFF);
          chk("b2b_second_cout", {31'd0, cout}, 32'd0);
          in_valid = 1'b0;
        end
      end
    end
    chk("b2b_first_latency", t1, NB + 1);
    chk("b2b_gap", t2 - t1, exp_gap);
    @(negedge clock);
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("b2b_drained", {31'd0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
